instr_fetch_unit: RTL and testbench

Instruction fetch stage of the 16-bit core, directly upstream of decode and immediate generation. It holds the PC and issues word-addressed requests to instruction memory. Returned 16-bit instruction words are buffered in a small in-order prefetch FIFO and presented to decode with a valid/ready handshake. Redirects from branch/jump resolution (BEQ, BNE, JMP) flush the buffer and drop stale in-flight responses.

---
 rtl/instr_fetch_unit.sv | 165 ++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, word requests to imem, in-order prefetch FIFO to decode.
// Ports: clk, rst (async high); imem_req_valid/ready, imem_addr;
//   imem_rsp_valid, imem_rsp_data; id_valid/ready, id_instr, id_pc;
//   redirect_valid, redirect_pc.
// Option: define IFU_BYPASS_EN for same-cycle response-to-decode bypass.
module instr_fetch_unit #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rsp_valid,
  input  logic [15:0]       imem_rsp_data,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [15:0]       id_instr,
  output logic [ADDR_W-1:0] id_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    FLUSH
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] pc;
  logic [15:0]       fifo_instr [DEPTH];
  logic [ADDR_W-1:0] fifo_pc [DEPTH];
  logic [ADDR_W-1:0] aq [DEPTH];
  logic [PW-1:0]     f_rd, f_wr;
  logic [PW-1:0]     a_rd, a_wr;
  logic [CW-1:0]     f_cnt;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     drop_cnt;

  logic          redir;
  logic          f_empty;
  logic          credit;
  logic          req_fire;
  logic          rsp_run;
  logic          byp;
  logic          push;
  logic          pop;
  logic [CW-1:0] inflight;
  logic [CW-1:0] drop_next;

  assign redir   = redirect_valid && (state_q != BOOT);
  assign f_empty = (f_cnt == '0);
  assign credit  = ({1'b0, f_cnt} + {1'b0, outstanding})
                   < (CW+1)'(DEPTH);

  assign imem_req_valid = (state_q == RUN) && !redirect_valid
                          && credit;
  assign imem_addr = pc;
  assign req_fire  = imem_req_valid && imem_req_ready;

  // Stray responses (nothing outstanding) are ignored.
  assign rsp_run = (state_q == RUN) && imem_rsp_valid
                   && (outstanding != '0) && !redir;

`ifdef IFU_BYPASS_EN
  assign byp = rsp_run && f_empty;
`else
  assign byp = 1'b0;
`endif

  assign id_valid = !f_empty || byp;
  assign id_instr = !f_empty ? fifo_instr[f_rd]
                  : (byp ? imem_rsp_data : 16'h0000);
  assign id_pc    = !f_empty ? fifo_pc[f_rd]
                  : (byp ? aq[a_rd] : '0);

  assign pop  = id_valid && id_ready && !f_empty;
  assign push = rsp_run && !(byp && id_ready);

  // Only one of outstanding / drop_cnt is ever non-zero, so their sum
  // is the number of responses still owed by memory.
  assign inflight  = outstanding + drop_cnt;
  assign drop_next = (imem_rsp_valid && (inflight != '0))
                   ? inflight - CW'(1) : inflight;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= BOOT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (redir && (drop_next != '0)) state_d = FLUSH;
      end
      FLUSH: begin
        if (redir)
          state_d = (drop_next != '0) ? FLUSH : RUN;
        else if ((drop_cnt == '0) ||
                 (imem_rsp_valid && (drop_cnt == CW'(1))))
          state_d = RUN;
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      f_rd        <= '0;
      f_wr        <= '0;
      a_rd        <= '0;
      a_wr        <= '0;
      f_cnt       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (redir) begin
      pc          <= redirect_pc;
      f_rd        <= '0;
      f_wr        <= '0;
      a_rd        <= '0;
      a_wr        <= '0;
      f_cnt       <= '0;
      outstanding <= '0;
      drop_cnt    <= drop_next;
    end else begin
      if (req_fire) begin
        pc   <= pc + ADDR_W'(1);
        a_wr <= a_wr + PW'(1);
      end
      if (rsp_run) a_rd <= a_rd + PW'(1);
      if (push)    f_wr <= f_wr + PW'(1);
      if (pop)     f_rd <= f_rd + PW'(1);
      outstanding <= outstanding + CW'(req_fire)
                     - CW'(rsp_run);
      f_cnt <= f_cnt + CW'(push) - CW'(pop);
      if ((state_q == FLUSH) && imem_rsp_valid
          && (drop_cnt != '0))
        drop_cnt <= drop_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) aq[a_wr] <= pc;
    if (push) begin
      fifo_instr[f_wr] <= imem_rsp_data;
      fifo_pc[f_wr]    <= aq[a_rd];
    end
  end

  a_rsp_owed: assert property (
    @(posedge clk) disable iff (rst)
    imem_rsp_valid |-> (inflight != '0)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: pipelined memory model, expected-word
// scoreboard and scheduled point checks, drained by one monitor.
module tb_instr_fetch_unit;

  localparam int K_REQV  = 0;
  localparam int K_ADDR  = 1;
  localparam int K_IDV   = 2;
  localparam int K_INSTR = 3;
  localparam int K_IDPC  = 4;
  localparam int K_NACC  = 5;
  localparam int K_DRAIN = 6;

`ifdef IFU_BYPASS_EN
  localparam int FIRST = 2;
`else
  localparam int FIRST = 3;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [7:0]  imem_addr;
  logic        imem_rsp_valid;
  logic [15:0] imem_rsp_data;
  logic        id_valid;
  logic        id_ready;
  logic [15:0] id_instr;
  logic [7:0]  id_pc;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;

  typedef struct {
    logic [15:0] instr;
    logic [7:0]  pc;
  } word_t;

  typedef struct {
    int at;
    int kind;
    int val;
  } pchk_t;

  typedef struct {
    logic [7:0] addr;
    int due;
  } mreq_t;

  word_t exp_q[$];
  pchk_t pq[$];
  mreq_t mq[$];

  int         cyc = 0;
  int         lat = 1;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         n_acc = 0;
  logic       hold = 1'b0;
  logic [7:0] exp_addr = 8'h00;
  word_t      mw;
  pchk_t      mp;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .ADDR_W(8),
    .DEPTH(2),
    .RESET_PC(8'h00)
  ) dut (
    .clk(clk),
    .rst(rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data),
    .id_valid(id_valid),
    .id_ready(id_ready),
    .id_instr(id_instr),
    .id_pc(id_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc)
  );

  // Memory model and decode-ready driver, just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      cyc = 0;
      mq.delete();
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 16'h0000;
      id_ready       = 1'b0;
    end else begin
      cyc++;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 16'hA000 | {8'h00, mq[0].addr};
        void'(mq.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
      end
      id_ready = !hold && (exp_q.size() > 0);
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h",
               nm, cyc, act, req);
    end
  endtask

  // Monitor: samples on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_addr = 8'h00;
      n_acc = 0;
    end else begin
      if (redirect_valid) exp_addr = redirect_pc;
      if (imem_req_valid && imem_req_ready) begin
        n_acc++;
        chk("req_addr", {24'h0, imem_addr}, {24'h0, exp_addr});
        mq.push_back('{imem_addr, cyc + lat});
        exp_addr = exp_addr + 8'd1;
      end
      if (id_valid && id_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", {24'h0, id_pc}, 32'hFFFF_FFFF);
        end else begin
          mw = exp_q.pop_front();
          chk("id_instr", {16'h0, id_instr}, {16'h0, mw.instr});
          chk("id_pc", {24'h0, id_pc}, {24'h0, mw.pc});
        end
      end
    end
    while (pq.size() > 0 && pq[0].at <= cyc) begin
      mp = pq.pop_front();
      if (mp.at < cyc) begin
        chk("missed_check", mp.at, cyc);
      end else begin
        case (mp.kind)
          K_REQV:  chk("req_valid", {31'h0, imem_req_valid}, mp.val);
          K_ADDR:  chk("imem_addr", {24'h0, imem_addr}, mp.val);
          K_IDV:   chk("id_valid", {31'h0, id_valid}, mp.val);
          K_INSTR: chk("id_instr_pt", {16'h0, id_instr}, mp.val);
          K_IDPC:  chk("id_pc_pt", {24'h0, id_pc}, mp.val);
          K_NACC:  chk("req_count", n_acc, mp.val);
          default: chk("drain", exp_q.size(), mp.val);
        endcase
      end
    end
  end

  task automatic pt(input int at, input int kind, input int val);
    pq.push_back('{at, kind, val});
  endtask

  task automatic goto(input int c);
    int g = 0;
    while (cyc < c && g < 200) begin
      @(posedge clk);
      #2;
      g++;
    end
  endtask

  task automatic do_reset(input int l);
    rst = 1'b1;
    lat = l;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic expect_run(input logic [7:0] start, input int n);
    logic [7:0] a;
    a = start;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{16'hA000 | {8'h00, a}, a});
      a = a + 8'd1;
    end
  endtask

  task automatic drain();
    int g = 0;
    while (exp_q.size() > 0 && g < 200) begin
      @(posedge clk);
      #2;
      g++;
    end
    pt(cyc, K_DRAIN, 0);
    @(posedge clk);
    #2;
  endtask

  task automatic redirect(input int c, input logic [7:0] tgt);
    goto(c);
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
  endtask

  initial begin
    rst            = 1'b1;
    imem_req_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 8'h00;

    // Straight-line fetch, 1-cycle memory.
    do_reset(1);
    pt(0, K_REQV, 0);
    pt(1, K_REQV, 1);
    pt(1, K_ADDR, 0);
    pt(FIRST - 1, K_IDV, 0);
    pt(FIRST, K_IDV, 1);
    expect_run(8'h00, 6);
    drain();

    // Decode stalled: credits cap requests at two.
    hold = 1'b1;
    do_reset(1);
    pt(5, K_INSTR, 16'hA000);
    pt(11, K_NACC, 2);
    pt(11, K_REQV, 0);
    pt(11, K_IDV, 1);
    pt(11, K_INSTR, 16'hA000);
    pt(11, K_IDPC, 0);
    expect_run(8'h00, 3);
    goto(11);
    hold = 1'b0;
    drain();

    // Redirect with two requests in flight, 3-cycle memory.
    do_reset(3);
    expect_run(8'h40, 3);
    pt(4, K_REQV, 0);
    pt(5, K_REQV, 0);
    pt(6, K_REQV, 1);
    pt(6, K_ADDR, 8'h40);
    redirect(3, 8'h40);
    goto(4);
    redirect_valid = 1'b0;
    drain();

    // Redirect together with a handshake and a response.
    do_reset(1);
    expect_run(8'h00, 1);
    expect_run(8'h10, 3);
    pt(3, K_IDV, 1);
    pt(4, K_IDV, 0);
    pt(4, K_REQV, 1);
    pt(4, K_ADDR, 8'h10);
    redirect(3, 8'h10);
    goto(4);
    redirect_valid = 1'b0;
    drain();

    // PC wrap from 8'hFF to 8'h00.
    do_reset(1);
    pt(2, K_ADDR, 8'hFE);
    redirect(1, 8'hFE);
    expect_run(8'hFE, 4);
    goto(2);
    redirect_valid = 1'b0;
    drain();

    // Reset asserted mid-flush.
    do_reset(3);
    redirect(4, 8'h20);
    pt(5, K_REQV, 0);
    pt(5, K_ADDR, 0);
    pt(5, K_IDV, 0);
    pt(5, K_INSTR, 0);
    pt(5, K_IDPC, 0);
    goto(5);
    redirect_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    pt(0, K_REQV, 0);
    pt(1, K_REQV, 1);
    pt(1, K_ADDR, 0);
    expect_run(8'h00, 3);
    drain();

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
